// File: rtl/alu_exec_unit_if.sv
// Issue and result handshake between the ReservationStation, the ALU unit and
// the LoadStoreBuffer. The slave modport is the execution unit's view.
interface alu_exec_unit_if;
  logic        _rs_valid;
  logic [4:0]  _rs_rob_id;
  logic [3:0]  _rs_op;
  logic [31:0] _rs_v1;
  logic [31:0] _rs_v2;
  logic        _rs_stall;
  logic        _alu_full;
  logic        _alu_ready;
  logic [4:0]  _alu_rob_id;
  logic [31:0] _alu_value;

  modport master (
    output _rs_valid, _rs_rob_id, _rs_op, _rs_v1, _rs_v2, _alu_full,
    input  _rs_stall, _alu_ready, _alu_rob_id, _alu_value
  );

  modport slave (
    input  _rs_valid, _rs_rob_id, _rs_op, _rs_v1, _rs_v2, _alu_full,
    output _rs_stall, _alu_ready, _alu_rob_id, _alu_value
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-cycle integer ALU feeding a 2-entry in-order result queue that drains
// to the LoadStoreBuffer under backpressure; flushable on mispredict.
module alu_exec_unit #(
  parameter int QDEPTH = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           _clear,
  alu_exec_unit_if.slave bus
);
  typedef struct packed {
    logic [4:0]  rob_id;
    logic [31:0] value;
  } ent_t;

  ent_t [QDEPTH-1:0] mem;
  ent_t              last_q;
  ent_t              head_ent;
  logic              head, tail;
  logic [1:0]        count;
  logic              push, pop;
  logic [31:0]       result;
  logic [4:0]        sh;
  logic [31:0]       v1, v2;

  assign v1 = bus._rs_v1;
  assign v2 = bus._rs_v2;
  assign sh = v2[4:0];

  always_comb begin
    result = '0;
    case (bus._rs_op)
      4'd0:        result = v1 + v2;
      4'd1:        result = v1 - v2;
      4'd2:        result = v1 & v2;
      4'd3:        result = v1 | v2;
      4'd4:        result = v1 ^ v2;
      4'd5:        result = v1 << sh;
      4'd6:        result = v1 >> sh;
      4'd7:        result = $unsigned($signed(v1) >>> sh);
      4'd8, 4'd12: result = {31'b0, $signed(v1) < $signed(v2)};
      4'd9, 4'd14: result = {31'b0, v1 < v2};
      4'd10:       result = {31'b0, v1 == v2};
      4'd11:       result = {31'b0, v1 != v2};
      4'd13:       result = {31'b0, $signed(v1) >= $signed(v2)};
      4'd15:       result = {31'b0, v1 >= v2};
      default:     result = '0;
    endcase
  end

  // Stall looks only at registered occupancy so the RS never sees a
  // combinational path from _alu_full.
  assign bus._rs_stall  = (count == 2'd2);
  assign bus._alu_ready = rdy_in & ~_clear & (count != 2'd0) & ~bus._alu_full;

  // When empty, present whatever was last shown rather than a stale slot.
  assign head_ent        = (count != 2'd0) ? mem[head] : last_q;
  assign bus._alu_rob_id = head_ent.rob_id;
  assign bus._alu_value  = head_ent.value;

  assign push = rdy_in & ~_clear & bus._rs_valid & ~bus._rs_stall;
  assign pop  = bus._alu_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem    <= '0;
      last_q <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else if (rdy_in) begin
      last_q <= head_ent;
      if (_clear) begin
        head  <= 1'b0;
        tail  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          mem[tail] <= '{rob_id: bus._rs_rob_id, value: result};
          tail      <= ~tail;
        end
        if (pop) head <= ~head;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against a queue-based
// behavioural model with arithmetic-derived ALU results.
module tb_alu_exec_unit;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    ._clear (clr),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  last_rob = '0;
  logic [31:0] last_val = '0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    longint unsigned ua  = {32'b0, a};
    longint unsigned ub  = {32'b0, b};
    longint unsigned una = {32'b0, ~a};
    longint          sa  = $signed(a);
    longint          sb  = $signed(b);
    longint unsigned p2  = 64'd1 << b[4:0];
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(ua * p2);
      4'd6:  return 32'(ua / p2);
      4'd7:  return (sa >= 0) ? 32'(ua / p2) : ~32'(una / p2);
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd10: return (ua == ub) ? 32'd1 : 32'd0;
      4'd11: return (ua != ub) ? 32'd1 : 32'd0;
      4'd12: return (sa < sb) ? 32'd1 : 32'd0;
      4'd13: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: return (ua < ub) ? 32'd1 : 32'd0;
      default: return (ua >= ub) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model, clock.
  task automatic cyc(input logic rst, rdy, c, full, v, input logic [4:0] rob,
                     input logic [3:0] op, input logic [31:0] a, b);
    logic        e_stall, e_rdy;
    logic [4:0]  e_rob;
    logic [31:0] e_val;
    ent_t        e;
    rst_in = rst; rdy_in = rdy; clr = c;
    bus._alu_full = full; bus._rs_valid = v; bus._rs_rob_id = rob;
    bus._rs_op = op; bus._rs_v1 = a; bus._rs_v2 = b;
    #1;
    e_stall = (q.size() == 2);
    e_rdy   = rdy && !c && (q.size() != 0) && !full;
    if (q.size() != 0) begin e_rob = q[0].rob; e_val = q[0].val; end
    else begin e_rob = last_rob; e_val = last_val; end
    chk("rs_stall",  {31'b0, bus._rs_stall},  {31'b0, e_stall});
    chk("alu_ready", {31'b0, bus._alu_ready}, {31'b0, e_rdy});
    chk("alu_rob_id", {27'b0, bus._alu_rob_id}, {27'b0, e_rob});
    chk("alu_value", bus._alu_value, e_val);
    if (rst) begin
      q.delete(); last_rob = '0; last_val = '0;
    end else if (rdy) begin
      last_rob = e_rob; last_val = e_val;
      if (c) q.delete();
      else begin
        if (e_rdy) e = q.pop_front();
        if (v && !e_stall) begin
          e.rob = rob; e.val = ref_alu(op, a, b);
          q.push_back(e);
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input logic full);
    cyc(1'b0, 1'b1, 1'b0, full, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic issue(input logic full, input logic [4:0] rob, input logic [3:0] op,
                       input logic [31:0] a, b);
    cyc(1'b0, 1'b1, 1'b0, full, 1'b1, rob, op, a, b);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr = 1'b0;
    bus._alu_full = 1'b0; bus._rs_valid = 1'b0; bus._rs_rob_id = '0;
    bus._rs_op = '0; bus._rs_v1 = '0; bus._rs_v2 = '0;
    @(negedge clk_in);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    chk("reset_stall", {31'b0, bus._rs_stall}, 32'd0);
    chk("reset_value", bus._alu_value, 32'd0);

    // Basic ADD: visible and transferred the cycle after issue, once.
    issue(1'b0, 5'd3, 4'd0, 32'd5, 32'd7);
    chk("add_ready", {31'b0, bus._alu_ready}, 32'd1);
    chk("add_rob", {27'b0, bus._alu_rob_id}, 32'd3);
    chk("add_value", bus._alu_value, 32'd12);
    idle(1'b0);
    chk("add_once", {31'b0, bus._alu_ready}, 32'd0);
    chk("add_hold", bus._alu_value, 32'd12);

    // Op sweep at full rate.
    issue(1'b0, 5'd1, 4'd1, 32'd0, 32'd1);
    chk("sub_value", bus._alu_value, 32'hFFFF_FFFF);
    issue(1'b0, 5'd2, 4'd7, 32'h8000_0000, 32'd4);
    chk("sra_value", bus._alu_value, 32'hF800_0000);
    issue(1'b0, 5'd3, 4'd6, 32'h8000_0000, 32'd4);
    chk("srl_value", bus._alu_value, 32'h0800_0000);
    issue(1'b0, 5'd4, 4'd8, 32'hFFFF_FFFF, 32'd1);
    chk("slt_value", bus._alu_value, 32'd1);
    issue(1'b0, 5'd5, 4'd9, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_value", bus._alu_value, 32'd0);
    issue(1'b0, 5'd6, 4'd15, 32'd5, 32'd5);
    chk("geu_value", bus._alu_value, 32'd1);
    issue(1'b0, 5'd7, 4'd5, 32'd1, 32'd33);
    chk("sll_value", bus._alu_value, 32'd2);
    idle(1'b0);

    // Backpressure: rob 3 held off by stall, drain in order.
    issue(1'b1, 5'd1, 4'd0, 32'd1, 32'd0);
    issue(1'b1, 5'd2, 4'd0, 32'd2, 32'd0);
    chk("bp_stall", {31'b0, bus._rs_stall}, 32'd1);
    issue(1'b1, 5'd3, 4'd0, 32'd3, 32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("bp_second", {27'b0, bus._alu_rob_id}, 32'd2);
    idle(1'b0);

    // Simultaneous push/pop stream.
    issue(1'b0, 5'd4, 4'd0, 32'd4, 32'd0);
    issue(1'b0, 5'd5, 4'd0, 32'd5, 32'd0);
    issue(1'b0, 5'd6, 4'd0, 32'd6, 32'd0);
    idle(1'b0);
    idle(1'b0);

    // Flush with two queued and a concurrent issue.
    issue(1'b1, 5'd7, 4'd0, 32'd7, 32'd0);
    issue(1'b1, 5'd8, 4'd0, 32'd8, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 4'd0, 32'd9, 32'd0);
    idle(1'b0);
    chk("flush_empty", {31'b0, bus._alu_ready}, 32'd0);
    idle(1'b0);

    // rdy_in low freezes everything, including _clear.
    issue(1'b1, 5'd10, 4'd0, 32'd10, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 4'd0, 32'd11, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 4'd0, 32'd11, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 4'd0, 32'd11, 32'd0);
    idle(1'b0);
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
          5'($urandom), 4'($urandom_range(0, 15)), rnd_val(), rnd_val());
    end

    // Reset mid-stream.
    issue(1'b1, 5'd20, 4'd0, 32'd20, 32'd0);
    issue(1'b1, 5'd21, 4'd0, 32'd21, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd22, 4'd0, 32'd22, 32'd0);
    chk("rst_ready", {31'b0, bus._alu_ready}, 32'd0);
    chk("rst_rob", {27'b0, bus._alu_rob_id}, 32'd0);
    chk("rst_value", bus._alu_value, 32'd0);
    issue(1'b0, 5'd23, 4'd1, 32'd30, 32'd8);
    chk("post_rst_value", bus._alu_value, 32'd22);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer execution unit between the ReservationStation issue port and the LoadStoreBuffer ALU result port. It accepts one issued ALU operation per cycle, computes a 32-bit result in a single combinational step, and holds results in a 2-entry result queue. The queue drains to the LoadStoreBuffer under that block's `_alu_full` backpressure, and the unit signals its own stall back to the ReservationStation. `_clear` flushes everything in flight on a mispredict.

## Interface
- `QDEPTH`, default 2: result queue depth. Fixed at 2; the pointers are 1 bit.
- `clk_in` in 1: system clock. All state updates on the rising edge.
- `rst_in` in 1: one clock; reset is synchronous and active-high.
- `rdy_in` in 1: when low, all state is frozen and `_alu_ready` is forced to 0.
- `_clear` in 1: pipeline flush; empties the queue.
- `_rs_valid` in 1: the ReservationStation is issuing an op this cycle.
- `_rs_rob_id` in 5: ROB tag of the issued op.
- `_rs_op` in 4: operation code, listed under Operation.
- `_rs_v1` in 32: operand 1.
- `_rs_v2` in 32: operand 2 (register value or immediate).
- `_rs_stall` out 1: the unit cannot accept an issue this cycle.
- `_alu_full` in 1: the LoadStoreBuffer cannot take a result this cycle.
- `_alu_ready` out 1: a result transfer occurs this cycle.
- `_alu_rob_id` out 5: ROB tag of the result at the queue head.
- `_alu_value` out 32: result value at the queue head.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA. Shift amount is `_rs_v2[4:0]`; SRA is sign-filling.
  - 8 SLT (signed), 9 SLTU.
  - 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU: branch compares returning 32'd1 or 32'd0.
- Arithmetic wraps modulo 2^32 with no overflow flag. All compare ops zero-extend their 1-bit result.
- Queue state: 2 entries, each holding {rob_id[4:0], value[31:0]}; head pointer, tail pointer, count 0..2. Pointers wrap 1→0.
- Push: occurs when `rdy_in & ~_clear & _rs_valid & ~_rs_stall`. The computed result is written at the tail.
- Pop: occurs when `_alu_ready`. The head advances.
- `_rs_stall` = (count == 2). It is a registered-state function and does not depend on a same-cycle pop.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- `_alu_ready` = `rdy_in & ~_clear & (count != 0) & ~_alu_full`.
- `_alu_rob_id` and `_alu_value` always reflect the head entry. They hold their last value when the queue is empty.
- `_clear`: count, head and tail all go to 0 at the next edge. The same-cycle issue is discarded and no pop occurs. `_clear` takes priority over push and pop.
- `rdy_in` low: no push, no pop, no pointer change. `_clear` is also ignored.
- Reset: count, head and tail go to 0, and every entry is zeroed. `_rs_stall`=0, `_alu_ready`=0, `_alu_rob_id`=0, `_alu_value`=0.

## Timing
- Issue in cycle N is visible at the head no earlier than N+1. Minimum issue-to-transfer latency is 1 cycle.
- Throughput is 1 result per cycle when `_alu_full` is low.
- Once count reaches 2, `_rs_stall` rises in the same cycle. It clears in the cycle after the first pop.
- `_alu_ready` is a 1-cycle strobe per transfer, and the LoadStoreBuffer samples it at the edge. A continuous high level means back-to-back transfers.
- Under `_alu_full`, results wait in order and none is dropped or reordered. Results leave in issue (FIFO) order.
- Reset mid-operation discards all entries; the first valid issue after reset is accepted in the next cycle.

## Test plan
- Basic op: ADD with v1=5, v2=7, rob 3, `_alu_full`=0 -> next cycle `_alu_ready`=1, rob_id=3, value=12, for one cycle only.
- Op sweep: SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; SLT -1<1 -> 1; SLTU -1<1 -> 0; GEU 5,5 -> 1; SLL by v2=33 -> shift by 1.
- Backpressure: hold `_alu_full`=1 and issue rob 1,2,3 on consecutive cycles -> `_rs_stall`=1 after the second push, rob 3 is held off by the RS. Release `_alu_full` -> outputs rob 1 then 2 on consecutive cycles; `_rs_stall` drops after the first pop.
- Simultaneous push/pop at count 1 with stream rob 4,5,6 at full rate -> count stays 1, outputs 4,5,6 in order with no bubble.
- Flush: with 2 queued results and `_clear`=1 plus `_rs_valid`=1 (rob 9) -> `_alu_ready`=0 that cycle, queue empty afterwards, rob 9 never emitted.
- `rdy_in`=0 for 3 cycles with 1 queued result -> no transfer and no push; the result emits in the first cycle `rdy_in`=1. Reset asserted mid-stream -> all outputs 0 next cycle.
